// File: rtl/linebuffer_mem_tile.sv
// Config-bus programmed memory tile: line buffer or FIFO over one DEPTH x DATA_WIDTH array.
// Every tile-ID-matched config pair is a register write; read_data echoes the post-write contents.
module linebuffer_mem_tile #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic [15:0]           tile_id,
    input  logic                  config_en,
    input  logic [31:0]           config_addr,
    input  logic [31:0]           config_data,
    output logic [31:0]           read_data,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  wen_in,
    input  logic                  ren_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full
);

    localparam logic [1:0]  MODE_LB   = 2'd1;
    localparam logic [1:0]  MODE_FIFO = 2'd2;
    localparam logic [AW:0] DEPTH_L   = DEPTH[AW:0];

    logic [1:0]            mode;
    logic [AW:0]           len_reg;
    logic [AW-1:0]         almost;
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic        cfg_hit;
    logic [7:0]  cfg_idx;
    logic        flush;
    logic [AW:0] eff_len;
    logic        active;
    logic        do_push;
    logic        do_pop;
    logic [AW+1:0] af_sum;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p, input logic [AW:0] lim);
        logic [AW:0] nxt;
        nxt = {1'b0, p} + 1'b1;
        wrap_inc = (nxt == lim) ? '0 : nxt[AW-1:0];
    endfunction

    // Handshake: a push/pop is taken in the cycle wen_in/ren_in is high and the
    // tile accepts it; there is no back-pressure output, refused requests are dropped.
    always_comb begin
        cfg_hit = config_en && (config_addr[15:0] == tile_id);
        cfg_idx = config_addr[31:24];
        flush   = cfg_hit && (cfg_idx == 8'h00 || cfg_idx == 8'h01);
        eff_len = (len_reg == '0 || len_reg > DEPTH_L) ? DEPTH_L : len_reg;
        active  = (mode == MODE_LB) || (mode == MODE_FIFO);
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!flush) begin
            if (mode == MODE_LB) begin
                do_push = wen_in;
                do_pop  = wen_in && (count == eff_len);
            end else if (mode == MODE_FIFO) begin
                do_pop  = ren_in && (count != '0);
                do_push = wen_in && ((count != eff_len) || do_pop);
            end
        end
    end

    always_comb begin
        af_sum       = {1'b0, count} + {2'b00, almost};
        empty        = !active || (count == '0);
        full         = active && (count == eff_len);
        almost_full  = active && (af_sum >= {1'b0, eff_len});
        almost_empty = !active || (count <= {1'b0, almost});
    end

    always_ff @(posedge clk_in) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // When full, rd_ptr == wr_ptr; the read returns the old word before the write lands.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            mode      <= '0;
            len_reg   <= '0;
            almost    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            read_data <= '0;
        end else begin
            if (cfg_hit) begin
                case (cfg_idx)
                    8'h00: begin
                        mode      <= config_data[1:0];
                        read_data <= {30'b0, config_data[1:0]};
                    end
                    8'h01: begin
                        len_reg   <= config_data[AW:0];
                        read_data <= {{(31-AW){1'b0}}, config_data[AW:0]};
                    end
                    8'h02: begin
                        almost    <= config_data[AW-1:0];
                        read_data <= {{(32-AW){1'b0}}, config_data[AW-1:0]};
                    end
                    default: read_data <= 32'hDEAD_BEEF;
                endcase
            end
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                valid_out <= 1'b0;
            end else begin
                valid_out <= do_pop;
                if (do_pop) begin
                    data_out <= mem[rd_ptr];
                    rd_ptr   <= wrap_inc(rd_ptr, eff_len);
                end
                if (do_push) begin
                    wr_ptr <= wrap_inc(wr_ptr, eff_len);
                end
                case ({do_push, do_pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_linebuffer_mem_tile.sv
// Bench for linebuffer_mem_tile: directed scenarios plus random traffic against a queue model.
module tb_linebuffer_mem_tile;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);
    localparam logic [15:0] TILE = 16'h0018;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [15:0] tile_id;
    logic        config_en;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic [31:0] read_data;
    logic [15:0] data_in;
    logic        wen_in;
    logic        ren_in;
    logic [15:0] data_out;
    logic        valid_out;
    logic        empty, full, almost_empty, almost_full;

    always #5 clk_in = ~clk_in;

    linebuffer_mem_tile #(.DATA_WIDTH(16), .DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .reset(reset), .tile_id(tile_id),
        .config_en(config_en), .config_addr(config_addr), .config_data(config_data),
        .read_data(read_data), .data_in(data_in), .wen_in(wen_in), .ren_in(ren_in),
        .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full)
    );

    // Scoreboard queues: expected data words, readbacks and {empty,full,almost_empty,almost_full}.
    logic [15:0] exp_q[$];
    logic [31:0] rd_q[$];
    logic [3:0]  flag_q[$];

    // Reference model: stored words kept oldest-first in a queue.
    int          m_mode;
    int          m_len;
    int          m_almost;
    logic [15:0] m_store[$];

    int total = 0;
    int bad   = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function logic [3:0] model_flags();
        int c;
        c = m_store.size();
        if (m_mode != 1 && m_mode != 2) return 4'b1010;
        return {c == 0, c == m_len, c <= m_almost, c + m_almost >= m_len};
    endfunction

    task automatic step(input bit rst, input bit ce, input logic [15:0] id, input logic [7:0] idx,
                        input logic [31:0] cd, input bit w, input bit r, input logic [15:0] d);
        bit hit, pop_ok, push_ok;
        int lv;
        @(negedge clk_in);
        reset       = rst;
        config_en   = ce;
        config_addr = {idx, 8'h00, id};
        config_data = cd;
        wen_in      = w;
        ren_in      = r;
        data_in     = d;
        if (rst) begin
            m_mode = 0; m_len = DEPTH; m_almost = 0;
            m_store.delete();
        end else begin
            hit = ce && (id == TILE);
            if (hit) begin
                case (idx)
                    8'h00: begin m_mode = int'(cd[1:0]); rd_q.push_back(32'(cd[1:0])); end
                    8'h01: begin
                        lv = int'(cd[AW:0]);
                        m_len = (lv == 0 || lv > DEPTH) ? DEPTH : lv;
                        rd_q.push_back(32'(cd[AW:0]));
                    end
                    8'h02: begin m_almost = int'(cd[AW-1:0]); rd_q.push_back(32'(cd[AW-1:0])); end
                    default: rd_q.push_back(32'hDEADBEEF);
                endcase
            end
            if (hit && idx <= 8'h01) begin
                m_store.delete();
            end else if (m_mode == 1 && w) begin
                if (m_store.size() == m_len) exp_q.push_back(m_store.pop_front());
                m_store.push_back(d);
            end else if (m_mode == 2) begin
                pop_ok  = r && m_store.size() > 0;
                push_ok = w && (m_store.size() < m_len || pop_ok);
                if (pop_ok) exp_q.push_back(m_store.pop_front());
                if (push_ok) m_store.push_back(d);
            end
        end
        flag_q.push_back(model_flags());
    endtask

    task automatic idle();                    step(0, 0, 16'h0, 8'h0, 32'h0, 0, 0, 16'h0); endtask
    task automatic cfg(input logic [7:0] i, input logic [31:0] v); step(0, 1, TILE, i, v, 0, 0, 16'h0); endtask
    task automatic push(input logic [15:0] d); step(0, 0, 16'h0, 8'h0, 32'h0, 1, 0, d); endtask
    task automatic pop();                     step(0, 0, 16'h0, 8'h0, 32'h0, 0, 1, 16'h0); endtask
    task automatic pushpop(input logic [15:0] d); step(0, 0, 16'h0, 8'h0, 32'h0, 1, 1, d); endtask

    // Monitor: checks whatever the DUT presents one time step after each rising edge.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (valid_out === 1'b1) begin
                if (exp_q.size() == 0) chk("spurious valid_out", 32'(valid_out), 32'h0);
                else                   chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
            end else if (exp_q.size() > 0) begin
                chk("valid_out missing", 32'(valid_out), 32'h1);
                void'(exp_q.pop_front());
            end
            if (rd_q.size() > 0)   chk("read_data", read_data, rd_q.pop_front());
            if (flag_q.size() > 0) chk("flags", 32'({empty, full, almost_empty, almost_full}), 32'(flag_q.pop_front()));
        end
    end

    initial begin
        reset = 1'b1; tile_id = TILE; config_en = 1'b0; config_addr = '0;
        config_data = '0; wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
        m_mode = 0; m_len = DEPTH; m_almost = 0;

        step(1, 0, 16'h0, 8'h0, 32'h0, 0, 0, 16'h0);
        step(1, 0, 16'h0, 8'h0, 32'h0, 0, 0, 16'h0);
        @(posedge clk_in);
        #2;
        chk("reset data_out", 32'(data_out), 32'h0);
        chk("reset valid_out", 32'(valid_out), 32'h0);
        chk("reset read_data", read_data, 32'h0);
        chk("reset flags", 32'({empty, full, almost_empty, almost_full}), 32'b1010);
        cfg(8'h00, 32'h0);

        // Foreign tile ID must not switch the mode on; pushes stay ignored.
        step(0, 1, 16'h0019, 8'h00, 32'h1, 0, 0, 16'h0);
        push(16'h0055);
        push(16'h0056);
        cfg(8'h00, 32'h1);

        cfg(8'h01, 32'h4);
        for (int i = 1; i <= 10; i++) push(16'(i));
        idle();

        cfg(8'h00, 32'h2);
        cfg(8'h01, 32'h8);
        cfg(8'h02, 32'h2);
        for (int i = 0; i < 9; i++) push(16'(i));
        for (int i = 0; i < 9; i++) pop();
        for (int i = 0; i < 8; i++) push(16'(16'h10 + i));
        pushpop(16'h00AA);
        for (int i = 0; i < 8; i++) pop();
        pushpop(16'h0033);
        idle();
        pop();
        cfg(8'h07, 32'h1234);

        for (int i = 0; i < 5; i++) push(16'(16'h40 + i));
        step(0, 1, TILE, 8'h01, 32'd16, 1, 1, 16'h0077);
        idle();
        pop();

        push(16'h0091);
        push(16'h0092);
        step(1, 0, 16'h0, 8'h0, 32'h0, 0, 1, 16'h0);
        idle();

        // Random FIFO traffic with occasional reconfiguration.
        cfg(8'h00, 32'h2);
        cfg(8'h01, 32'($urandom_range(0, 31)));
        cfg(8'h02, 32'($urandom_range(0, 15)));
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3)
                step(0, 1, ($urandom_range(0, 1) == 1) ? TILE : 16'($urandom),
                     8'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1,
                     $urandom_range(0, 1) == 1, 16'($urandom));
            else
                step(0, 0, 16'h0, 8'h0, 32'h0, $urandom_range(0, 99) < 55,
                     $urandom_range(0, 99) < 45, 16'($urandom));
            if (m_mode != 2 && $urandom_range(0, 9) == 0) cfg(8'h00, 32'h2);
        end

        cfg(8'h00, 32'h1);
        cfg(8'h01, 32'($urandom_range(1, 16)));
        for (int i = 0; i < 200; i++)
            step(0, 0, 16'h0, 8'h0, 32'h0, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 1) == 1, 16'($urandom));

        repeat (3) idle();
        for (int i = 0; i < 10 && (exp_q.size() > 0 || flag_q.size() > 0 || rd_q.size() > 0); i++)
            @(posedge clk_in);
        #2;
        if (exp_q.size() > 0 || rd_q.size() > 0)
            chk("drain", 32'(exp_q.size() + rd_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/linebuffer_mem_tile.md
# linebuffer_mem_tile

Parametrised memory tile core that the CGRA config bus programs and that serves as either a line buffer or a FIFO. It replaces the fixed 16-bit memory tile in the array and adds parametrised data width and depth, runtime mode/depth registers, occupancy flags and config readback. It sits behind the tile's routing switchboxes, takes config address/data pairs from the global config bus, and ignores any pair that does not carry its tile ID.

## Interface
Parameters:
- DATA_WIDTH, 16, data word width.
- DEPTH, 1024, storage words; a power of two ≥ 4.
- AW, $clog2(DEPTH), pointer width (derived).

Ports:
- clk_in  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- tile_id  in  16  this tile's ID.
- config_en  in  1  config pair valid this cycle.
- config_addr  in  32  [15:0] is the tile ID, [31:24] is the register index.
- config_data  in  32  config write data.
- read_data  out  32  registered readback of the addressed register.
- data_in  in  DATA_WIDTH  stream input.
- wen_in  in  1  push data_in.
- ren_in  in  1  pop request (FIFO mode only).
- data_out  out  DATA_WIDTH  registered output word.
- valid_out  out  1  data_out is valid this cycle.
- empty, full  out  1  occupancy flags.
- almost_empty, almost_full  out  1  thresholded flags.

## Operation
- Register writes occur when config_en=1 and config_addr[15:0]==tile_id; other IDs have no effect.
- Registers:
  - 0x00 MODE[1:0]: 0=off, 1=linebuffer, 2=fifo, 3=off.
  - 0x01 LEN[AW:0]: line length or FIFO capacity. 0 or any value >DEPTH means DEPTH.
  - 0x02 ALMOST[AW-1:0]: flag threshold.
- Readback: on a tile-ID match, read_data takes the indexed register one cycle later, zero-extended. It reads 0xDEADBEEF for an unknown index. It holds its value when there is no match.
- A write to MODE or LEN flushes the storage state: wr_ptr, rd_ptr and count return to 0 and valid_out goes to 0. Memory contents are not cleared.
- Storage: a DEPTH×DATA_WIDTH array with one write port and one registered read port. Pointers wrap modulo LEN, not modulo DEPTH.
- Off mode: pushes and pops are ignored, valid_out=0, and the flags report as empty.
- Linebuffer mode: each wen_in writes at wr_ptr.
  - While count<LEN, count increments and there is no output.
  - Once count==LEN, each wen_in also reads the oldest word. data_out equals the sample pushed exactly LEN pushes earlier and valid_out=1 for one cycle.
  - ren_in is ignored.
- FIFO mode:
  - Push is accepted when !full, or when full with a pop in the same cycle.
  - Pop is accepted when !empty.
  - A push and pop in the same cycle leave count unchanged.
  - A push into an empty FIFO with a pop in the same cycle: the pop is rejected because it is evaluated against the pre-cycle count.
  - A rejected push or pop is dropped silently with no state change.
- Flags:
  - empty = count==0.
  - full = count==LEN.
  - almost_full = count ≥ LEN−ALMOST.
  - almost_empty = count ≤ ALMOST.
- count is AW+1 bits and never exceeds LEN.

## Timing
- Reset values: data_out=0, valid_out=0, read_data=0, empty=1, full=0, almost_empty=1, almost_full=0, MODE=0, LEN=0 (which acts as DEPTH), ALMOST=0, and all pointers and count are 0.
- Flags are combinational from registered count, so they update in the cycle after the push or pop.
- Data latency is 1 cycle. Linebuffer: data_out and valid_out follow the wen_in cycle. FIFO: they follow the accepted pop cycle.
- valid_out is a one-cycle pulse for each accepted read.
- Reset has priority over everything, including a config write in the same cycle.
- A config flush in the same cycle as wen_in or ren_in: the flush wins and the push or pop is discarded.
- Reset or flush mid-stream: any in-flight output is suppressed the next cycle (valid_out=0).

## Test plan
- Reset: after 2 cycles with reset=1, every output equals its reset value, and a readback of 0x00 gives read_data=0.
- ID filter: write 0x01 to MODE with tile_id=0x18 and config_addr[15:0]=0x19, then read back MODE at 0x18 → read_data=0 (ignored). Repeat the write with 0x18 → read_data=1.
- Linebuffer: MODE=1, LEN=4, push 1,2,3,…,10 on consecutive cycles.
  - valid_out stays 0 for the first 4 pushes.
  - Then data_out = 1,2,…,6, each one cycle after pushes 5–10.
- FIFO full/empty: MODE=2, LEN=8, ALMOST=2.
  - Push 8 → full=1; almost_full=1 from count 6.
  - A 9th push is dropped.
  - Pop 8 → data 0..7 in order with valid_out pulses, then empty=1.
  - A 9th pop gives valid_out=0.
- Simultaneous at boundaries:
  - At full, push 0xAA with a concurrent pop → count stays 8, and 0xAA emerges after 8 further pops.
  - At empty, push and pop together → pop rejected, count=1.
- Reconfig flush: mid-stream in FIFO with count=5, write LEN=16 → next cycle count=0, empty=1, valid_out=0, and the concurrent push is discarded.
